// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle unsigned MULTU/DIVU unit with architectural HI/LO registers.
// It also handles MTHI/MTLO, and its HI/LO outputs feed the MFHI/MFLO path.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] md_a,
  input  logic [WIDTH-1:0] md_b,
  output logic             md_busy,
  output logic             md_done,
  output logic             md_div_by_zero,
  output logic [WIDTH-1:0] md_hi,
  output logic [WIDTH-1:0] md_lo
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0]       OP_DIVU   = 2'b01;
  localparam logic [1:0]       OP_MTHI   = 2'b10;
  localparam logic [1:0]       OP_MTLO   = 2'b11;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   iter_cnt;
  logic               is_div;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;

  // acc holds {partial product, remaining multiplier} for MULTU and
  // {partial remainder, dividend/quotient} for DIVU; opnd is multiplicand or divisor.
  always_comb begin
    addend    = acc[0] ? opnd : '0;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    rem_diff  = rem_shift - {1'b0, opnd};
    acc_next  = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (rem_shift >= {1'b0, opnd})
        acc_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      iter_cnt       <= '0;
      is_div         <= 1'b0;
      opnd           <= '0;
      acc            <= '0;
      md_busy        <= 1'b0;
      md_done        <= 1'b0;
      md_div_by_zero <= 1'b0;
      md_hi          <= '0;
      md_lo          <= '0;
    end else begin
      case (state)
        IDLE: begin
          md_done <= 1'b0;
          if (md_start) begin
            case (md_op)
              OP_MTHI: md_hi <= md_a;
              OP_MTLO: md_lo <= md_a;
              default: begin
                state          <= RUN;
                md_busy        <= 1'b1;
                md_div_by_zero <= 1'b0;
                iter_cnt       <= '0;
                is_div         <= (md_op == OP_DIVU);
                opnd           <= (md_op == OP_DIVU) ? md_b : md_a;
                acc            <= {{WIDTH{1'b0}}, (md_op == OP_DIVU) ? md_a : md_b};
              end
            endcase
          end
        end
        // A zero divisor needs no special path: every trial subtraction
        // succeeds, giving an all-ones quotient and the dividend as remainder.
        RUN: begin
          acc      <= acc_next;
          iter_cnt <= iter_cnt + CNT_W'(1);
          if (iter_cnt == LAST_ITER) begin
            state          <= DONE;
            md_busy        <= 1'b0;
            md_done        <= 1'b1;
            md_hi          <= acc_next[2*WIDTH-1:WIDTH];
            md_lo          <= acc_next[WIDTH-1:0];
            md_div_by_zero <= is_div && (opnd == '0);
          end
        end
        DONE: begin
          md_done <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: stimulus pushes expected HI/LO results,
// and a negedge monitor pops and compares them whenever md_done pulses.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_busy;
  logic        md_done;
  logic        md_div_by_zero;
  logic [31:0] md_hi;
  logic [31:0] md_lo;

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .md_start       (md_start),
    .md_op          (md_op),
    .md_a           (md_a),
    .md_b           (md_b),
    .md_busy        (md_busy),
    .md_done        (md_done),
    .md_div_by_zero (md_div_by_zero),
    .md_hi          (md_hi),
    .md_lo          (md_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          accept;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors      = 0;
  int          miscompares  = 0;
  int          cycle        = 0;
  int          busy_samples = 0;
  logic [31:0] mdl_hi       = '0;
  logic [31:0] mdl_lo       = '0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [65:0] actual, input logic [65:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference behaviour straight from the arithmetic definition of each op.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [63:0] p;
    r.accept = 0;
    if (op == 2'b00) begin
      p     = 64'(a) * 64'(b);
      r.hi  = p[63:32];
      r.lo  = p[31:0];
      r.dbz = 1'b0;
    end else if (b == 32'd0) begin
      r.hi  = a;
      r.lo  = 32'hFFFF_FFFF;
      r.dbz = 1'b1;
    end else begin
      r.hi  = a % b;
      r.lo  = a / b;
      r.dbz = 1'b0;
    end
    return r;
  endfunction

  // Monitor: while busy, HI/LO must hold the last committed values and the flag
  // must be clear; on done, pop the scoreboard and check result and timing.
  // Timing counts clock edges inclusively from the accept edge: the result must be
  // visible after the 33rd edge, and busy must be high after the first 32 edges.
  always @(negedge clk) begin
    exp_t e;
    if (md_busy === 1'b1) begin
      busy_samples++;
      checkOutput("hold_during_run", {1'b0, md_div_by_zero, md_hi, md_lo}, {2'b00, mdl_hi, mdl_lo});
    end
    if (md_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_done: got done=1, expected done=0 with no pending op");
      end else begin
        e = exp_q.pop_front();
        checkOutput("result", {1'b0, md_div_by_zero, md_hi, md_lo}, {1'b0, e.dbz, e.hi, e.lo});
        checkOutput("done_latency", 66'(cycle - e.accept + 1), 66'd33);
        checkOutput("busy_edges", 66'(busy_samples + 1), 66'd33);
        checkOutput("busy_at_done", 66'(md_busy), 66'd0);
        mdl_hi = e.hi;
        mdl_lo = e.lo;
      end
      busy_samples = 0;
    end
  end

  // Issue one request from IDLE. A noisy request scrambles the operands and
  // pokes MTLO starts throughout RUN and during the DONE cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit noisy);
    exp_t e;
    bit   seen;
    md_start = 1'b1;
    md_op    = op;
    md_a     = a;
    md_b     = b;
    if (op[1]) begin
      @(posedge clk); #1;
      md_start = 1'b0;
      if (op == 2'b10) begin
        mdl_hi = a;
        checkOutput("mthi", {md_busy, md_done, md_hi, md_lo}, {2'b00, mdl_hi, mdl_lo});
      end else begin
        mdl_lo = a;
        checkOutput("mtlo", {md_busy, md_done, md_hi, md_lo}, {2'b00, mdl_hi, mdl_lo});
      end
    end else begin
      e        = model(op, a, b);
      e.accept = cycle + 1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      md_start = 1'b0;
      seen     = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (md_done) begin
          seen = 1'b1;
          break;
        end
        if (noisy) begin
          md_a     = $urandom;
          md_b     = $urandom;
          md_op    = 2'b11;
          md_start = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
      end
      if (!seen) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL done_timeout: got no done within 40 cycles, expected done after 33");
        md_start = 1'b0;
      end else begin
        if (noisy) begin
          md_start = 1'b1;
          md_op    = 2'b11;
          md_a     = $urandom;
        end
        @(posedge clk); #1;
        md_start = 1'b0;
        checkOutput("after_done", {md_busy, md_done, md_hi, md_lo}, {2'b00, e.hi, e.lo});
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;

    rst      = 1'b1;
    md_start = 1'b0;
    md_op    = 2'b00;
    md_a     = '0;
    md_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_flags", {63'd0, md_busy, md_done, md_div_by_zero}, 66'd0);
    checkOutput("reset_hilo", {2'b00, md_hi, md_lo}, 66'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] MULTU max operands");
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checkOutput("mul_max", {2'b00, md_hi, md_lo}, {2'b00, 64'hFFFF_FFFE_0000_0001});

    $display("[TB] DIVU 100/7 with operand noise");
    applyStimulus(2'b01, 32'd100, 32'd7, 1'b1);
    checkOutput("div_100_7", {1'b0, md_div_by_zero, md_hi, md_lo}, {2'b00, 32'd2, 32'd14});

    $display("[TB] DIVU by zero");
    applyStimulus(2'b01, 32'h1234_5678, 32'd0, 1'b0);
    checkOutput("div_zero", {1'b0, md_div_by_zero, md_hi, md_lo}, {2'b01, 32'h1234_5678, 32'hFFFF_FFFF});

    $display("[TB] MULTU 3*5 clears div_by_zero");
    applyStimulus(2'b00, 32'd3, 32'd5, 1'b0);
    checkOutput("mul_3_5", {1'b0, md_div_by_zero, md_hi, md_lo}, {2'b00, 32'd0, 32'd15});

    $display("[TB] MTHI then MTLO back to back");
    md_start = 1'b1;
    md_op    = 2'b10;
    md_a     = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    checkOutput("mthi_back2back", {md_busy, md_done, md_hi}, {2'b00, 32'hDEAD_BEEF});
    md_op = 2'b11;
    md_a  = 32'h0BAD_F00D;
    @(posedge clk); #1;
    md_start = 1'b0;
    checkOutput("mtlo_back2back", {md_busy, md_done, md_hi, md_lo}, {2'b00, 32'hDEAD_BEEF, 32'h0BAD_F00D});
    mdl_hi = 32'hDEAD_BEEF;
    mdl_lo = 32'h0BAD_F00D;

    $display("[TB] reset in the middle of a MULTU");
    md_start = 1'b1;
    md_op    = 2'b00;
    md_a     = 32'h89AB_CDEF;
    md_b     = 32'h0001_2345;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    mdl_hi       = '0;
    mdl_lo       = '0;
    busy_samples = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("reset_mid_run", {md_busy, md_done, md_div_by_zero, 31'd0, md_hi, md_lo}, 66'd0);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("no_commit_after_reset", {md_busy, md_done, md_hi, md_lo}, 66'd0);

    $display("[TB] randomized operations");
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      op = 2'b00;
      else if (sel < 8) op = 2'b01;
      else if (sel == 8) op = 2'b10;
      else              op = 2'b11;
      a = $urandom;
      if ($urandom_range(0, 7) == 0)      b = 32'd0;
      else if ($urandom_range(0, 1) == 1) b = $urandom;
      else                                b = 32'($urandom_range(1, 1000));
      applyStimulus(op, a, b, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    #1;
    checkOutput("queue_drained", 66'(exp_q.size()), 66'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
